buffered_multicast_fork: RTL and testbench



---
 rtl/buffered_multicast_fork.sv | 86 ++++++++
 tb/tb_buffered_multicast_fork.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_multicast_fork.sv
// buffered_multicast_fork: one producer fanned out to NumOutputs consumers.
// Each token carries a destination mask and is copied into a private FIFO
// per selected output, so one stalled consumer only holds back the producer
// once its own FIFO is full and the next token wants that channel.
//
// Handshake: on every channel, input and output alike, a transfer happens
// in a cycle where valid=1 and bp=0 at the rising clock edge. bp is allowed
// to be asserted while valid=0 and is then simply ignored.
module buffered_multicast_fork #(
   parameter  int Width      = 8,
   parameter  int NumOutputs = 4,
   parameter  int Depth      = 2,
   localparam int CW         = $clog2(Depth + 1),
   localparam int PW         = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [Width-1:0]           din,
   input  logic                       din_valid,
   input  logic [NumOutputs-1:0]      din_mask,
   output logic                       din_bp,
   output logic [NumOutputs*Width-1:0] dout,
   output logic [NumOutputs-1:0]      dout_valid,
   input  logic [NumOutputs-1:0]      dout_bp,
   output logic [NumOutputs*CW-1:0]   dout_level
);

   // Pointer advance with explicit wrap, so Depth=1 keeps pointers at 0.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [NumOutputs-1:0] full_vec;
   logic                  accept;

   // Acceptance is all-or-nothing: any selected channel that is full stalls
   // the whole token. Full comes from registered counts only, so a pop in
   // the same cycle never lets a push through a full channel.
   assign din_bp = |(din_mask & full_vec);
   assign accept = din_valid & ~din_bp;

   for (genvar i = 0; i < NumOutputs; i++) begin : g_ch
      logic [Width-1:0] mem [Depth];
      logic [PW-1:0]    rdptr;
      logic [PW-1:0]    wrptr;
      logic [CW-1:0]    count;
      logic             push;
      logic             pop;

      assign full_vec[i]            = (count == CW'(Depth));
      assign push                   = accept & din_mask[i];
      assign pop                    = (count != '0) & ~dout_bp[i];
      assign dout_valid[i]          = (count != '0);
      assign dout[i*Width +: Width] = mem[rdptr];
      assign dout_level[i*CW +: CW] = count;

      // Storage write; contents are never visible until counted, so no reset.
      always_ff @(posedge clk) begin
         if (push) begin
            mem[wrptr] <= din;
         end
      end

      // Pointer and occupancy bookkeeping; reset empties the channel.
      always_ff @(posedge clk) begin
         if (!resetn) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
         end else begin
            if (push) begin
               wrptr <= next_ptr(wrptr);
            end
            if (pop) begin
               rdptr <= next_ptr(rdptr);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_buffered_multicast_fork.sv
// Bench for buffered_multicast_fork: directed scenarios plus a randomized
// run, all checked against per-channel expected queues.
module tb_buffered_multicast_fork;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [W-1:0]   din;
  logic           din_valid;
  logic [N-1:0]   din_mask;
  logic           din_bp;
  logic [N*W-1:0] dout;
  logic [N-1:0]   dout_valid;
  logic [N-1:0]   dout_bp;
  logic [N*CW-1:0] dout_level;

  int checks = 0;
  int errors = 0;

  // Expected contents of every channel FIFO, front = next token out.
  logic [W-1:0] exp_q [N][$];

  buffered_multicast_fork #(.Width(W), .NumOutputs(N), .Depth(D)) dut (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .din_mask(din_mask), .din_bp(din_bp), .dout(dout),
    .dout_valid(dout_valid), .dout_bp(dout_bp), .dout_level(dout_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dout_of(int i);
    return dout[i*W +: W];
  endfunction

  function automatic logic [CW-1:0] level_of(int i);
    return dout_level[i*CW +: CW];
  endfunction

  // Reference rule: the producer stalls if any selected channel holds Depth tokens.
  function automatic logic model_bp();
    for (int i = 0; i < N; i++)
      if (din_mask[i] && exp_q[i].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the reference by one edge using the current inputs, then clock.
  task automatic cycle();
    logic acc;
    if (!resetn) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      acc = din_valid && !model_bp();
      for (int i = 0; i < N; i++)
        if (exp_q[i].size() > 0 && !dout_bp[i]) void'(exp_q[i].pop_front());
      if (acc)
        for (int i = 0; i < N; i++)
          if (din_mask[i]) exp_q[i].push_back(din);
    end
    @(posedge clk);
    #1;
  endtask

  // Continuous invariants: occupancy bounded, no push into a full channel.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (level_of(i) > CW'(D)) begin
          errors++;
          $display("FAIL level_bound ch%0d got %0d max %0d", i, level_of(i), D);
        end
        checks++;
        if (din_valid && !din_bp && din_mask[i] && level_of(i) == CW'(D)) begin
          errors++;
          $display("FAIL push_when_full ch%0d accepted with level %0d", i, level_of(i));
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0; din = '0; din_valid = 1'b0; din_mask = '0; dout_bp = '0;
    cycle(); cycle();
    resetn = 1'b1; din_mask = '1;
    #1;
    checks++;
    if (dout_valid !== '0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++;
    if (dout_level !== '0) begin errors++; $display("FAIL reset_level got %h exp 0", dout_level); end
    checks++;
    if (din_bp !== 1'b0) begin errors++; $display("FAIL reset_bp got %b exp 0", din_bp); end
    din_mask = '0;
  endtask

  task automatic test_broadcast();
    logic [W-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    dout_bp = '0; din_mask = 4'b1111; din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = vals[k];
      #1;
      checks++;
      if (din_bp !== 1'b0) begin errors++; $display("FAIL bcast_bp tok%0d got %b exp 0", k, din_bp); end
      cycle();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dout_valid[i] !== 1'b1 || dout_of(i) !== vals[k]) begin
          errors++; $display("FAIL bcast_data ch%0d got %b/%h exp 1/%h", i, dout_valid[i], dout_of(i), vals[k]);
        end
        checks++;
        if (level_of(i) !== CW'(1)) begin errors++; $display("FAIL bcast_level ch%0d got %0d exp 1", i, level_of(i)); end
      end
    end
    din_valid = 1'b0;
    cycle();
    checks++;
    if (dout_valid !== '0) begin errors++; $display("FAIL bcast_drain got %b exp 0", dout_valid); end
  endtask

  task automatic test_slow_consumer();
    dout_bp = 4'b0100; din_mask = 4'b1111; din_valid = 1'b1;
    din = 8'hA0; #1;
    checks++;
    if (din_bp !== 1'b0) begin errors++; $display("FAIL slow_bp_a0 got %b exp 0", din_bp); end
    cycle();
    din = 8'hA1; #1;
    checks++;
    if (din_bp !== 1'b0) begin errors++; $display("FAIL slow_bp_a1 got %b exp 0", din_bp); end
    cycle();
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        checks++;
        if (dout_of(i) !== 8'hA1 || level_of(i) !== CW'(1)) begin
          errors++; $display("FAIL slow_fast_ch%0d got %h/%0d exp a1/1", i, dout_of(i), level_of(i));
        end
      end
    end
    checks++;
    if (dout_of(2) !== 8'hA0 || level_of(2) !== CW'(2)) begin
      errors++; $display("FAIL slow_ch2 got %h/%0d exp a0/2", dout_of(2), level_of(2));
    end
    din = 8'hA2; #1;
    checks++;
    if (din_bp !== 1'b1) begin errors++; $display("FAIL slow_bp_a2 got %b exp 1", din_bp); end
    cycle();
    checks++;
    if (dout_valid !== 4'b0100) begin errors++; $display("FAIL slow_stalled_valid got %b exp 0100", dout_valid); end
    dout_bp = '0; #1;
    checks++;
    if (din_bp !== 1'b1) begin errors++; $display("FAIL slow_bp_release got %b exp 1", din_bp); end
    cycle();
    checks++;
    if (dout_of(2) !== 8'hA1 || level_of(2) !== CW'(1) || din_bp !== 1'b0) begin
      errors++; $display("FAIL slow_after_pop got %h/%0d/%b exp a1/1/0", dout_of(2), level_of(2), din_bp);
    end
    cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dout_valid[i] !== 1'b1 || dout_of(i) !== 8'hA2) begin
        errors++; $display("FAIL slow_a2 ch%0d got %b/%h exp 1/a2", i, dout_valid[i], dout_of(i));
      end
    end
    din_valid = 1'b0;
    cycle();
  endtask

  task automatic test_mask();
    dout_bp = 4'b0100; din_mask = 4'b0100; din_valid = 1'b1;
    din = 8'h01; cycle();
    din = 8'h02; cycle();
    checks++;
    if (level_of(2) !== CW'(2)) begin errors++; $display("FAIL mask_fill got %0d exp 2", level_of(2)); end
    din = 8'h55; din_mask = 4'b1011; #1;
    checks++;
    if (din_bp !== 1'b0) begin errors++; $display("FAIL mask_bp got %b exp 0", din_bp); end
    cycle();
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        checks++;
        if (dout_valid[i] !== 1'b1 || dout_of(i) !== 8'h55) begin
          errors++; $display("FAIL mask_ch%0d got %b/%h exp 1/55", i, dout_valid[i], dout_of(i));
        end
      end
    end
    checks++;
    if (dout_of(2) !== 8'h01 || level_of(2) !== CW'(2)) begin
      errors++; $display("FAIL mask_ch2 got %h/%0d exp 01/2", dout_of(2), level_of(2));
    end
    din_valid = 1'b0;
  endtask

  task automatic test_zero_mask();
    logic [N-1:0]    v_before;
    logic [N*CW-1:0] l_before;
    dout_bp = '1; din = 8'hFF; din_mask = '0; din_valid = 1'b1;
    #1;
    checks++;
    if (din_bp !== 1'b0) begin errors++; $display("FAIL zero_bp got %b exp 0", din_bp); end
    v_before = dout_valid; l_before = dout_level;
    cycle();
    checks++;
    if (dout_valid !== v_before || dout_level !== l_before) begin
      errors++; $display("FAIL zero_state got %b/%h exp %b/%h", dout_valid, dout_level, v_before, l_before);
    end
    din_valid = 1'b0; dout_bp = '0;
    cycle(); cycle(); cycle();
    checks++;
    if (dout_valid !== '0) begin errors++; $display("FAIL zero_drain got %b exp 0", dout_valid); end
  endtask

  task automatic test_full_pop_push();
    logic [W-1:0] obs [$];
    int idx;
    logic acc;
    dout_bp = 4'b0001; din_mask = 4'b0001; din_valid = 1'b1;
    din = 8'h60; cycle();
    din = 8'h61; cycle();
    checks++;
    if (level_of(0) !== CW'(2)) begin errors++; $display("FAIL fpp_fill got %0d exp 2", level_of(0)); end
    din = 8'h62; dout_bp = '0; #1;
    checks++;
    if (din_bp !== 1'b1) begin errors++; $display("FAIL fpp_bp_full got %b exp 1", din_bp); end
    if (dout_valid[0] && !dout_bp[0]) obs.push_back(dout_of(0));
    cycle();
    checks++;
    if (level_of(0) !== CW'(1) || dout_of(0) !== 8'h61) begin
      errors++; $display("FAIL fpp_pop got %0d/%h exp 1/61", level_of(0), dout_of(0));
    end
    dout_bp = 4'b0001; #1;
    checks++;
    if (din_bp !== 1'b0) begin errors++; $display("FAIL fpp_bp_free got %b exp 0", din_bp); end
    cycle();
    checks++;
    if (level_of(0) !== CW'(2)) begin errors++; $display("FAIL fpp_refill got %0d exp 2", level_of(0)); end
    idx = 3;
    for (int c = 0; c < 60 && (idx < 6 || exp_q[0].size() > 0); c++) begin
      din = 8'h60 + W'(idx); din_valid = (idx < 6);
      dout_bp = {3'b000, 1'($urandom_range(0, 1))};
      #1;
      checks++;
      if (din_bp !== model_bp()) begin errors++; $display("FAIL fpp_bp_run got %b exp %b", din_bp, model_bp()); end
      acc = din_valid && !din_bp;
      if (dout_valid[0] && !dout_bp[0]) obs.push_back(dout_of(0));
      cycle();
      if (acc) idx++;
      checks++;
      if (level_of(0) !== CW'(exp_q[0].size())) begin
        errors++; $display("FAIL fpp_level got %0d exp %0d", level_of(0), exp_q[0].size());
      end
    end
    din_valid = 1'b0; dout_bp = '0;
    checks++;
    if (obs.size() != 6 || exp_q[0].size() != 0) begin
      errors++; $display("FAIL fpp_count got %0d exp 6", obs.size());
    end
    for (int k = 0; k < obs.size(); k++) begin
      checks++;
      if (obs[k] !== 8'h60 + W'(k)) begin errors++; $display("FAIL fpp_order pos%0d got %h exp %h", k, obs[k], 8'h60 + W'(k)); end
    end
  endtask

  task automatic test_reset_mid();
    dout_bp = 4'b0010; din_mask = 4'b0010; din_valid = 1'b1;
    din = 8'h71; cycle();
    din = 8'h72; cycle();
    checks++;
    if (level_of(1) !== CW'(2)) begin errors++; $display("FAIL rmid_fill got %0d exp 2", level_of(1)); end
    resetn = 1'b0; din = 8'h99; din_mask = '1;
    cycle();
    resetn = 1'b1; din_valid = 1'b0;
    #1;
    checks++;
    if (dout_valid !== '0 || dout_level !== '0 || din_bp !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got %b/%h/%b exp 0/0/0", dout_valid, dout_level, din_bp);
    end
    dout_bp = '0;
    cycle();
    checks++;
    if (dout_valid !== '0) begin errors++; $display("FAIL rmid_nostore got %b exp 0", dout_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      din_mask  = N'($urandom);
      for (int i = 0; i < N; i++) dout_bp[i] = ($urandom_range(0, 2) == 0);
      if (c >= 200 && c < 260) dout_bp = dout_bp | 4'b1001;
      #1;
      checks++;
      if (din_bp !== model_bp()) begin errors++; $display("FAIL rand_bp cyc%0d got %b exp %b", c, din_bp, model_bp()); end
      cycle();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dout_valid[i] !== (exp_q[i].size() != 0)) begin
          errors++; $display("FAIL rand_valid cyc%0d ch%0d got %b exp %b", c, i, dout_valid[i], exp_q[i].size() != 0);
        end
        checks++;
        if (level_of(i) !== CW'(exp_q[i].size())) begin
          errors++; $display("FAIL rand_level cyc%0d ch%0d got %0d exp %0d", c, i, level_of(i), exp_q[i].size());
        end
        if (exp_q[i].size() != 0) begin
          checks++;
          if (dout_of(i) !== exp_q[i][0]) begin
            errors++; $display("FAIL rand_data cyc%0d ch%0d got %h exp %h", c, i, dout_of(i), exp_q[i][0]);
          end
        end
      end
    end
    din_valid = 1'b0; dout_bp = '0;
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_slow_consumer();
    test_mask();
    test_zero_mask();
    test_full_pop_push();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
